// File: rtl/tts_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Pure declarations: no latency.
// No flow control.
package tts_pkg;

  // Default circuit width and the truth-table width that follows from it
  localparam int N_IN_DFLT = 3;
  localparam int TT_W      = 2**N_IN_DFLT;

  // Settle counter width: covers SETTLE values 0..15
  localparam int SETTLE_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

endpackage

// File: rtl/tts_settle_cnt.sv
// Loadable down-counter that times how long each input code is held.
// Load and decrement take effect at the next clock edge.
// No flow control: decrement saturates at zero.
module tts_settle_cnt
  import tts_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] cnt;

  // Load takes priority over decrement; the counter never wraps below zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // last: the decrement happening this cycle brings the count to zero
  assign zero = (cnt == '0);
  assign last = (cnt == W'(1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input code into a combinational circuit, samples f_in, and compares the truth table.
// Latency: 2**N_IN*(SETTLE+1)+1 cycles from accepted start to the done pulse.
// No backpressure: start is ignored while busy and in the done cycle. Optional TTS_ERR_LOG_EN adds err_idx/err_vld.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int N_IN   = N_IN_DFLT,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   exp_tt,
  input  logic                 f_in,
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   tt_out
`ifdef TTS_ERR_LOG_EN
  ,
  output logic [N_IN-1:0]      err_idx,
  output logic                 err_vld
`endif
);

  localparam int TW = 2**N_IN;
  localparam int IW = N_IN + 1;

  localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);
  localparam logic [IW-1:0]       LAST_IDX = IW'(TW - 1);
  // With no settle time each code goes straight to sampling
  localparam state_t              ADV_ST   = (SETTLE == 0) ? SAMPLE : HOLD;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_inc;
  logic [TW-1:0]   exp_latched;

  logic            accept;
  logic            do_sample;
  logic            do_check;
  logic            cnt_load;
  logic            cnt_dec;
  logic            cnt_zero;
  logic            cnt_last;

  assign idx_inc = idx + 1'b1;

  tts_settle_cnt #(
    .W (SETTLE_W)
  ) u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (SETTLE_V),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state control strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    do_sample = 1'b0;
    do_check  = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        // The done cycle is spent in IDLE; a start seen then is dropped
        if (start && !done) begin
          accept    = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = ADV_ST;
        end
      end
      HOLD: begin
        cnt_dec = 1'b1;
        if (cnt_last || cnt_zero) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        do_sample = 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = CHECK;
        end else begin
          cnt_load  = 1'b1;
          state_nxt = ADV_ST;
        end
      end
      CHECK: begin
        do_check  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: code stepping, capture, and final verdict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_out     <= '0;
      tt_out      <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      idx         <= '0;
      exp_latched <= '0;
    end else begin
      done <= do_check;
      if (accept) begin
        exp_latched <= exp_tt;
        idx         <= '0;
        vec_out     <= '0;
        tt_out      <= '0;
        pass        <= 1'b0;
      end
      if (do_sample) begin
        tt_out[idx[N_IN-1:0]] <= f_in;
        if (idx != LAST_IDX) begin
          idx     <= idx_inc;
          vec_out <= idx_inc[N_IN-1:0];
        end
      end
      // tt_out already holds the final sample written on the previous edge
      if (do_check) begin
        pass <= (tt_out == exp_latched);
      end
    end
  end

  // busy spans the whole sweep plus the done cycle
  assign busy = (state != IDLE) || done;

`ifdef TTS_ERR_LOG_EN
  // Record the first code whose sample disagrees with the expected table
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_idx <= '0;
      err_vld <= 1'b0;
    end else if (accept) begin
      err_idx <= '0;
      err_vld <= 1'b0;
    end else if (do_sample && !err_vld && (f_in != exp_latched[idx[N_IN-1:0]])) begin
      err_idx <= idx[N_IN-1:0];
      err_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0;
  logic       start0 = 1'b0;
  logic [7:0] exp1 = 8'h00;
  logic [7:0] exp0 = 8'h00;
  logic       f1, f0;
  logic [2:0] vec1, vec0;
  logic       busy1, busy0, done1, done0, pass1, pass0;
  logic [7:0] tt1, tt0;
`ifdef TTS_ERR_LOG_EN
  logic [2:0] eidx1, eidx0;
  logic       evld1, evld0;
`endif

  // Circuits under test: parity on the SETTLE=1 instance, x&y|z on the SETTLE=0 instance
  assign f1 = vec1[2] ^ vec1[1] ^ vec1[0];
  assign f0 = (vec0[2] & vec0[1]) | vec0[0];

  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .exp_tt(exp1), .f_in(f1),
    .vec_out(vec1), .busy(busy1), .done(done1), .pass(pass1), .tt_out(tt1)
`ifdef TTS_ERR_LOG_EN
    , .err_idx(eidx1), .err_vld(evld1)
`endif
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .exp_tt(exp0), .f_in(f0),
    .vec_out(vec0), .busy(busy0), .done(done0), .pass(pass0), .tt_out(tt0)
`ifdef TTS_ERR_LOG_EN
    , .err_idx(eidx0), .err_vld(evld0)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] tt;
    logic       pass;
    logic [2:0] eidx;
    logic       evld;
    int         s;
    int         lat;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitor for the SETTLE=1 instance
  bit   post1 = 0;
  exp_t e1;
  always @(negedge clk) begin
    if (post1) begin
      chk("dut1 busy after done", busy1, 0);
      chk("dut1 done width", done1, 0);
      chk("dut1 vec holds last", vec1, 7);
      post1 = 0;
    end
    if (done1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected done: got done=1 expected none (t=%0t)", $time);
      end else begin
        e1 = q1.pop_front();
        chk("dut1 tt_out", tt1, e1.tt);
        chk("dut1 pass", pass1, e1.pass);
        chk("dut1 latency", cyc - e1.s, e1.lat);
        chk("dut1 busy in done", busy1, 1);
`ifdef TTS_ERR_LOG_EN
        chk("dut1 err_vld", evld1, e1.evld);
        if (e1.evld) chk("dut1 err_idx", eidx1, e1.eidx);
`endif
      end
      post1 = 1;
    end
  end

  // Monitor for the SETTLE=0 instance
  bit   post0 = 0;
  exp_t e0;
  always @(negedge clk) begin
    if (post0) begin
      chk("dut0 busy after done", busy0, 0);
      chk("dut0 done width", done0, 0);
      chk("dut0 vec holds last", vec0, 7);
      post0 = 0;
    end
    if (done0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected done: got done=1 expected none (t=%0t)", $time);
      end else begin
        e0 = q0.pop_front();
        chk("dut0 tt_out", tt0, e0.tt);
        chk("dut0 pass", pass0, e0.pass);
        chk("dut0 latency", cyc - e0.s, e0.lat);
        chk("dut0 busy in done", busy0, 1);
`ifdef TTS_ERR_LOG_EN
        chk("dut0 err_vld", evld0, e0.evld);
        if (e0.evld) chk("dut0 err_idx", eidx0, e0.eidx);
`endif
      end
      post0 = 1;
    end
  end

  function automatic exp_t mk(input logic [7:0] tt, input logic p, input logic [2:0] ei,
                              input logic ev, input int s, input int lat);
    exp_t e;
    e.tt = tt; e.pass = p; e.eidx = ei; e.evld = ev; e.s = s; e.lat = lat;
    return e;
  endfunction

  // One start pulse on the SETTLE=1 instance; expectation queued after the start edge
  task automatic sweep1(input logic [7:0] et, input logic [7:0] tt, input logic p,
                        input logic [2:0] ei, input logic ev, input bit push);
    @(negedge clk);
    exp1 = et; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    if (push) q1.push_back(mk(tt, p, ei, ev, cyc, 17));
  endtask

  task automatic sweep0(input logic [7:0] et, input logic [7:0] tt, input logic p,
                        input logic [2:0] ei, input logic ev);
    @(negedge clk);
    exp0 = et; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    q0.push_back(mk(tt, p, ei, ev, cyc, 9));
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (q1.size() == 0 && q0.size() == 0 && !busy1 && !busy0) ok = 1;
    end
    @(negedge clk);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle timeout: got q1=%0d q0=%0d expected both empty", q1.size(), q0.size());
    end
  endtask

  initial begin
    int s;
    bit found;

    // 1. Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset vec_out", vec1, 0);
    chk("reset busy", busy1, 0);
    chk("reset done", done1, 0);
    chk("reset pass", pass1, 0);
    chk("reset tt_out", tt1, 0);
    chk("reset dut0 busy", busy0, 0);
`ifdef TTS_ERR_LOG_EN
    chk("reset err_vld", evld1, 0);
`endif

    // 2. Parity, matching table; vec_out steps every 2 cycles; exp changed mid-sweep
    sweep1(8'h96, 8'h96, 1'b1, 3'd0, 1'b0, 1'b1);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      chk("dut1 vec step", vec1, j / 2);
      if (j == 3) exp1 = 8'h00;
    end
    wait_idle();

    // 3. Parity, wrong expected table: mismatch at code 0
    sweep1(8'h97, 8'h96, 1'b0, 3'd0, 1'b1, 1'b1);
    wait_idle();

    // 4. SETTLE=0, x&y|z, with start pulses while busy
    sweep0(8'hEA, 8'hEA, 1'b1, 3'd0, 1'b0);
    @(negedge clk); @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk); @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle();
    sweep0(8'h6A, 8'hEA, 1'b0, 3'd7, 1'b1);
    wait_idle();

    // 5. Reset mid-sweep at vec_out==3
    sweep1(8'h96, 8'h96, 1'b1, 3'd0, 1'b0, 1'b0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (vec1 == 3'd3) found = 1;
    end
    chk("reach vec_out 3", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort vec_out", vec1, 0);
    chk("abort busy", busy1, 0);
    chk("abort done", done1, 0);
    chk("abort pass", pass1, 0);
    chk("abort tt_out", tt1, 0);
`ifdef TTS_ERR_LOG_EN
    chk("abort err_vld", evld1, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("no busy after abort", busy1, 0);
    sweep1(8'h96, 8'h96, 1'b1, 3'd0, 1'b0, 1'b1);
    wait_idle();

    // 6. start held high: back-to-back sweeps with one IDLE cycle between them
    @(negedge clk);
    exp0 = 8'hEA; start0 = 1'b1;
    @(posedge clk);
    #1 s = cyc;
    for (int k = 0; k < 3; k++) begin
      q0.push_back(mk(8'hEA, 1'b1, 3'd0, 1'b0, s, 9));
      if (k < 2) begin
        repeat (11) @(posedge clk);
        #1 s = s + 11;
      end
    end
    repeat (8) @(posedge clk);
    #1 start0 = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
